branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
Sequences PC redirects from the memory-access stage of the two-slot VLIW core. Takes per-slot branch-resolution results: slot 1 is older, slot 2 is younger. Selects the oldest redirect and hands the target PC to fetch with a valid/ready handshake. Flushes younger pipeline stages for a fixed drain window, ignores wrong-path resolutions meanwhile, and counts redirects for performance debug.

Parameters:
FLUSH_CYCLES, 3, cycles flush stays asserted after the redirect handshake completes; legal range 1..15
CNT_W, 32, width of the redirect performance counter

Ports:
clk  in  1  core clock, rising edge
rstn  in  1  asynchronous active-low reset
m1_valid  in  1  slot-1 instruction valid in memory-access stage
m1_redirect  in  1  slot-1 branch unit demands redirect (mispredict or taken-unpredicted)
m1_dest  in  32  slot-1 resolved next PC (branch target or pc+1)
m2_valid  in  1  slot-2 instruction valid
m2_redirect  in  1  slot-2 redirect demand
m2_dest  in  32  slot-2 resolved next PC
redir_ready  in  1  fetch accepts redirect this cycle
redir_valid  out  1  redirect request to fetch
redir_pc  out  32  redirect target, stable while redir_valid=1
flush  out  1  kill all younger in-flight instructions (fetch/decode/execute)
squash_m2  out  1  combinational: suppress slot-2 writeback this cycle
busy  out  1  state != IDLE
redirect_count  out  CNT_W  number of accepted redirects, saturating

Behaviour:
- States: IDLE, REDIRECT, DRAIN. All state and output registers reset asynchronously on rstn=0. Reset values: redir_valid=0, redir_pc=0, flush=0, busy=0, redirect_count=0. A drain counter also resets to 0.
- IDLE, event capture:
  - hit1 = m1_valid & m1_redirect; hit2 = m2_valid & m2_redirect.
  - If hit1: latch redir_pc<=m1_dest, go to REDIRECT. Slot 2 is discarded.
  - Else if hit2: latch m2_dest, go to REDIRECT.
  - Else stay in IDLE.
- squash_m2 = (state==IDLE) & hit1 | (state!=IDLE) & m2_valid. This is combinational, same cycle.
- REDIRECT:
  - redir_valid=1 and flush=1, both registered. They are asserted in the cycle after capture, giving latency 1.
  - Hold redir_valid and redir_pc until redir_valid & redir_ready. On handshake, load drain counter with FLUSH_CYCLES and go to DRAIN.
  - redirect_count increments by 1 on handshake and saturates at all-ones.
- DRAIN:
  - redir_valid=0, flush=1. The counter decrements each cycle.
  - When the counter reaches 1, flush deasserts on the next edge together with the return to IDLE. flush is therefore high for exactly FLUSH_CYCLES cycles after the handshake cycle.
- Wrong-path suppression: in REDIRECT and DRAIN, all m1/m2 redirect inputs are ignored and never latched or queued.
- Backpressure: redir_ready may stay low for any number of cycles. REDIRECT holds indefinitely with flush held high.
- Handshake timing: redir_ready=1 in the first REDIRECT cycle completes the handshake that cycle, with no extra bubble.
- Return to IDLE: the first IDLE cycle samples inputs normally, so back-to-back redirects are possible with one IDLE cycle between them.
- Reset mid-operation: immediate return to IDLE. Any in-progress redirect is dropped with no partial handshake, and the counter clears.
- redir_pc is only meaningful while redir_valid=1. It retains its last value otherwise.

Decomposition:
- Shared package (core-wide):
  - state encoding constants IDLE=2'b00, REDIRECT=2'b01, DRAIN=2'b10
  - PC width constant (32)
  - FLUSH_CYCLES default
- One sub-module, redirect_perf_counter: saturating CNT_W counter with increment enable and async active-low reset. It is reused later for other pipeline statistics.
- All remaining logic (slot priority, FSM, drain counter) stays in the top module.

Test Plan:
- Slot-1 priority: m1 redirect to 0x100 and m2 redirect to 0x200 in the same cycle, redir_ready=1 -> squash_m2=1 that cycle; next cycle redir_valid=1, redir_pc=0x100; count=1.
- Slot-2 only: m2 redirect to 0x2A0, m1_valid=1 with m1_redirect=0 -> squash_m2=0; redir_pc=0x2A0 one cycle later.
- Backpressure: redir_ready=0 for 5 cycles, then 1 -> redir_valid and redir_pc=0x100 held 6 cycles; flush high for those 6 plus exactly 3 more; count increments once.
- Wrong path: a new m1 redirect to 0x300 during DRAIN -> ignored, no second redir_valid, count unchanged; a redirect in the first IDLE cycle afterwards is accepted.
- Reset mid-REDIRECT: rstn low asynchronously between clock edges -> redir_valid, flush, busy and count go to 0 immediately; FSM in IDLE after release.
- Saturation: preload count to 2^CNT_W-1 (force or CNT_W=4 instance), perform a redirect -> count stays at all-ones.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared core-wide definitions for the memory-stage PC redirect logic.
package branch_redirect_ctrl_pkg;

   // Redirect sequencer state encoding
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      REDIRECT = 2'b01,
      DRAIN    = 2'b10
   } redir_state_t;

   // Program counter width of the core
   localparam int PC_W = 32;

   // Default number of flush cycles that follow an accepted redirect
   localparam int FLUSH_CYCLES_DEF = 3;

endpackage : branch_redirect_ctrl_pkg

// File: rtl/redirect_perf_counter.sv
// Saturating event counter with increment enable, used for pipeline statistics.
module redirect_perf_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_r;

   // Count enabled events and hold at all-ones once saturated
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_r <= {W{1'b0}};
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule : redirect_perf_counter

// File: rtl/branch_redirect_ctrl.sv
// Sequences PC redirects from the memory-access stage of the two-slot core:
// picks the oldest redirecting slot, hands its target to fetch over a
// valid/ready handshake, then holds flush for a fixed drain window.
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             m1_valid,
   input  logic             m1_redirect,
   input  logic [PC_W-1:0]  m1_dest,
   input  logic             m2_valid,
   input  logic             m2_redirect,
   input  logic [PC_W-1:0]  m2_dest,
   input  logic             redir_ready,
   output logic             redir_valid,
   output logic [PC_W-1:0]  redir_pc,
   output logic             flush,
   output logic             squash_m2,
   output logic             busy,
   output logic [CNT_W-1:0] redirect_count
);

   // Drain counter is 4 bits wide, enough for the 1..15 flush window
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   redir_state_t    state_r;
   logic [3:0]      drain_cnt_r;
   logic            redir_valid_r;
   logic [PC_W-1:0] redir_pc_r;
   logic            flush_r;
   logic            busy_r;

   logic            hit1_s;
   logic            hit2_s;
   logic            squash_m2_s;
   logic            accept_s;

   // Slot hit detection, same-cycle slot-2 squash and handshake detect
   always_comb begin
      hit1_s   = m1_valid & m1_redirect;
      hit2_s   = m2_valid & m2_redirect;
      accept_s = (state_r == REDIRECT) & redir_valid_r & redir_ready;
      if (state_r == IDLE) begin
         squash_m2_s = hit1_s;
      end else begin
         squash_m2_s = m2_valid;
      end
   end

   // Redirect FSM: capture oldest hit, hold until accepted, then drain
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r       <= IDLE;
         drain_cnt_r   <= 4'd0;
         redir_valid_r <= 1'b0;
         redir_pc_r    <= 32'h0000_0000;
         flush_r       <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (hit1_s) begin
                  redir_pc_r    <= m1_dest;
                  state_r       <= REDIRECT;
                  redir_valid_r <= 1'b1;
                  flush_r       <= 1'b1;
                  busy_r        <= 1'b1;
               end else if (hit2_s) begin
                  redir_pc_r    <= m2_dest;
                  state_r       <= REDIRECT;
                  redir_valid_r <= 1'b1;
                  flush_r       <= 1'b1;
                  busy_r        <= 1'b1;
               end else begin
                  state_r       <= IDLE;
                  redir_valid_r <= 1'b0;
                  flush_r       <= 1'b0;
                  busy_r        <= 1'b0;
               end
            end
            REDIRECT: begin
               // Wrong-path resolutions are ignored; only the handshake matters
               if (accept_s) begin
                  state_r       <= DRAIN;
                  drain_cnt_r   <= FLUSH_LOAD;
                  redir_valid_r <= 1'b0;
               end else begin
                  state_r       <= REDIRECT;
                  redir_valid_r <= 1'b1;
               end
               flush_r <= 1'b1;
               busy_r  <= 1'b1;
            end
            DRAIN: begin
               if (drain_cnt_r <= 4'd1) begin
                  state_r     <= IDLE;
                  drain_cnt_r <= 4'd0;
                  flush_r     <= 1'b0;
                  busy_r      <= 1'b0;
               end else begin
                  state_r     <= DRAIN;
                  drain_cnt_r <= drain_cnt_r - 4'd1;
                  flush_r     <= 1'b1;
                  busy_r      <= 1'b1;
               end
               redir_valid_r <= 1'b0;
            end
            default: begin
               state_r       <= IDLE;
               drain_cnt_r   <= 4'd0;
               redir_valid_r <= 1'b0;
               flush_r       <= 1'b0;
               busy_r        <= 1'b0;
            end
         endcase
      end
   end

   redirect_perf_counter #(
      .W (CNT_W)
   ) u_perf_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (accept_s),
      .count (redirect_count)
   );

   assign redir_valid = redir_valid_r;
   assign redir_pc    = redir_pc_r;
   assign flush       = flush_r;
   assign busy        = busy_r;
   assign squash_m2   = squash_m2_s;

endmodule : branch_redirect_ctrl

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: slot priority, backpressure,
// wrong-path suppression, asynchronous reset and counter saturation.
module tb_branch_redirect_ctrl;

   logic        clk;
   logic        rstn;
   logic        m1_valid;
   logic        m1_redirect;
   logic [31:0] m1_dest;
   logic        m2_valid;
   logic        m2_redirect;
   logic [31:0] m2_dest;
   logic        redir_ready;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        flush;
   logic        squash_m2;
   logic        busy;
   logic [31:0] redirect_count;

   logic        s_redir_valid;
   logic [31:0] s_redir_pc;
   logic        s_flush;
   logic        s_squash_m2;
   logic        s_busy;
   logic [3:0]  s_count;

   int tests_run;
   int tests_failed;

   branch_redirect_ctrl #(
      .FLUSH_CYCLES (3),
      .CNT_W        (32)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .m1_valid       (m1_valid),
      .m1_redirect    (m1_redirect),
      .m1_dest        (m1_dest),
      .m2_valid       (m2_valid),
      .m2_redirect    (m2_redirect),
      .m2_dest        (m2_dest),
      .redir_ready    (redir_ready),
      .redir_valid    (redir_valid),
      .redir_pc       (redir_pc),
      .flush          (flush),
      .squash_m2      (squash_m2),
      .busy           (busy),
      .redirect_count (redirect_count)
   );

   // Narrow-counter instance sharing the same stimulus, for saturation
   branch_redirect_ctrl #(
      .FLUSH_CYCLES (3),
      .CNT_W        (4)
   ) dut_sat (
      .clk            (clk),
      .rstn           (rstn),
      .m1_valid       (m1_valid),
      .m1_redirect    (m1_redirect),
      .m1_dest        (m1_dest),
      .m2_valid       (m2_valid),
      .m2_redirect    (m2_redirect),
      .m2_dest        (m2_dest),
      .redir_ready    (redir_ready),
      .redir_valid    (s_redir_valid),
      .redir_pc       (s_redir_pc),
      .flush          (s_flush),
      .squash_m2      (s_squash_m2),
      .busy           (s_busy),
      .redirect_count (s_count)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m1_valid    = 1'b0;
      m1_redirect = 1'b0;
      m2_valid    = 1'b0;
      m2_redirect = 1'b0;
   endtask

   // One complete slot-1 redirect with fetch always ready, then wait for IDLE
   task automatic do_redirect(input logic [31:0] dest);
      int n;
      m1_valid    = 1'b1;
      m1_redirect = 1'b1;
      m1_dest     = dest;
      redir_ready = 1'b1;
      step();
      clear_inputs();
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         chk("redirect_timeout", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rstn         = 1'b0;
      clear_inputs();
      m1_dest      = 32'h0;
      m2_dest      = 32'h0;
      redir_ready  = 1'b0;

      // Reset state
      #3;
      chk("rst_valid", 32'(redir_valid), 32'd0);
      chk("rst_pc", redir_pc, 32'h0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", redirect_count, 32'd0);
      step();
      rstn = 1'b1;
      step();

      // Slot-1 priority over slot 2
      m1_valid = 1'b1; m1_redirect = 1'b1; m1_dest = 32'h100;
      m2_valid = 1'b1; m2_redirect = 1'b1; m2_dest = 32'h200;
      redir_ready = 1'b1;
      #1;
      chk("prio_squash", 32'(squash_m2), 32'd1);
      chk("prio_busy_idle", 32'(busy), 32'd0);
      step();
      clear_inputs();
      chk("prio_valid", 32'(redir_valid), 32'd1);
      chk("prio_pc", redir_pc, 32'h100);
      chk("prio_flush", 32'(flush), 32'd1);
      chk("prio_busy", 32'(busy), 32'd1);
      chk("prio_cnt_before", redirect_count, 32'd0);
      step();
      chk("prio_drain_valid", 32'(redir_valid), 32'd0);
      chk("prio_drain_flush", 32'(flush), 32'd1);
      chk("prio_count", redirect_count, 32'd1);
      m2_valid = 1'b1;
      #1;
      chk("drain_squash_m2", 32'(squash_m2), 32'd1);
      m2_valid = 1'b0;
      step();
      chk("prio_drain2_flush", 32'(flush), 32'd1);
      step();
      chk("prio_drain3_flush", 32'(flush), 32'd1);
      step();
      chk("prio_idle_flush", 32'(flush), 32'd0);
      chk("prio_idle_busy", 32'(busy), 32'd0);

      // Slot-2 only redirect
      m1_valid = 1'b1; m1_redirect = 1'b0; m1_dest = 32'h150;
      m2_valid = 1'b1; m2_redirect = 1'b1; m2_dest = 32'h2A0;
      #1;
      chk("s2_squash", 32'(squash_m2), 32'd0);
      step();
      clear_inputs();
      chk("s2_valid", 32'(redir_valid), 32'd1);
      chk("s2_pc", redir_pc, 32'h2A0);
      step(); step(); step(); step();
      chk("s2_idle_busy", 32'(busy), 32'd0);
      chk("s2_count", redirect_count, 32'd2);

      // Backpressure: fetch stalls 5 cycles, accepts on the 6th
      redir_ready = 1'b0;
      m1_valid = 1'b1; m1_redirect = 1'b1; m1_dest = 32'h100;
      step();
      clear_inputs();
      for (int i = 0; i < 6; i++) begin
         chk("bp_valid", 32'(redir_valid), 32'd1);
         chk("bp_pc", redir_pc, 32'h100);
         chk("bp_flush", 32'(flush), 32'd1);
         chk("bp_count_held", redirect_count, 32'd2);
         if (i == 5) begin
            redir_ready = 1'b1;
         end
         step();
      end
      // Wrong-path slot-1 redirect during drain is ignored
      m1_valid = 1'b1; m1_redirect = 1'b1; m1_dest = 32'h300;
      for (int i = 0; i < 3; i++) begin
         chk("bp_drain_flush", 32'(flush), 32'd1);
         chk("wp_no_valid", 32'(redir_valid), 32'd0);
         if (i == 2) begin
            clear_inputs();
         end
         step();
      end
      chk("bp_end_flush", 32'(flush), 32'd0);
      chk("bp_end_busy", 32'(busy), 32'd0);
      chk("bp_count", redirect_count, 32'd3);
      // Redirect in the first IDLE cycle is accepted
      m1_valid = 1'b1; m1_redirect = 1'b1; m1_dest = 32'h340;
      #1;
      chk("b2b_squash", 32'(squash_m2), 32'd1);
      step();
      clear_inputs();
      chk("b2b_valid", 32'(redir_valid), 32'd1);
      chk("b2b_pc", redir_pc, 32'h340);
      step(); step(); step(); step();
      chk("b2b_count", redirect_count, 32'd4);
      chk("b2b_idle", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of REDIRECT
      redir_ready = 1'b0;
      m2_valid = 1'b1; m2_redirect = 1'b1; m2_dest = 32'h500;
      step();
      clear_inputs();
      chk("rr_valid_pre", 32'(redir_valid), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("rr_valid", 32'(redir_valid), 32'd0);
      chk("rr_flush", 32'(flush), 32'd0);
      chk("rr_busy", 32'(busy), 32'd0);
      chk("rr_count", redirect_count, 32'd0);
      #1;
      rstn = 1'b1;
      step();
      chk("rr_idle_busy", 32'(busy), 32'd0);
      chk("rr_idle_valid", 32'(redir_valid), 32'd0);
      do_redirect(32'h600);
      chk("rr_count_after", redirect_count, 32'd1);

      // Saturation of the 4-bit instance (already at 1 after reset test)
      for (int i = 0; i < 14; i++) begin
         do_redirect(32'h700 + 32'(i));
      end
      chk("sat_at_max", 32'(s_count), 32'd15);
      do_redirect(32'h800);
      chk("sat_held", 32'(s_count), 32'd15);
      chk("wide_count", redirect_count, 32'd16);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_branch_redirect_ctrl
